// File: rtl/ipsxb_fft_frame_chk.sv
// ipsxb_fft_frame_chk
//   Checks the FFT IP AXI4-Stream result port: framing (tlast vs. length N),
//   output bin order (tuser), and per-frame signature consistency. The frame
//   generator repeats the same input and alternates FFT/IFFT, so even frames
//   must reproduce frame 0's signature and odd frames frame 1's.
// Ports
//   i_aclk, i_aresetn        clock, async active-low reset
//   i_aclken                 clock enable qualifying every state update
//   i_start_test             (re)start a test; wins over any sample that cycle
//   i_axi4s_data_t*          result stream {im,re}, tlast, tuser = bin index
//   o_chk_finished/o_chk_pass  test done / done with no error flag
//   o_err_*                  sticky error flags (len, idx, sig, timeout)
//   o_frm_cnt, o_last_sig    completed frames, signature of latest frame
module ipsxb_fft_frame_chk #(
  parameter int TEST_FRAME_NUM = 10,
  parameter int LOGS_FFT_LEN   = 4,
  parameter int OUTPUT_WIDTH   = 16,
  parameter int OUT_ORDER      = 0,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int DATAOUT_WIDTH  = ((OUTPUT_WIDTH + 7) / 8) * 8
) (
  input  logic                                    i_aclk,
  input  logic                                    i_aresetn,
  input  logic                                    i_aclken,
  input  logic                                    i_start_test,
  input  logic                                    i_axi4s_data_tvalid,
  input  logic [2*DATAOUT_WIDTH-1:0]              i_axi4s_data_tdata,
  input  logic                                    i_axi4s_data_tlast,
  input  logic [LOGS_FFT_LEN-1:0]                 i_axi4s_data_tuser,
  output logic                                    o_chk_finished,
  output logic                                    o_chk_pass,
  output logic                                    o_err_len,
  output logic                                    o_err_idx,
  output logic                                    o_err_sig,
  output logic                                    o_err_timeout,
  output logic [$clog2(TEST_FRAME_NUM+1)-1:0]     o_frm_cnt,
  output logic [31:0]                             o_last_sig
);
  localparam int FW  = $clog2(TEST_FRAME_NUM + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW  = ((2 * OUTPUT_WIDTH + 31) / 32) * 32;
  localparam int NCH = SW / 32;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [LOGS_FFT_LEN-1:0] cnt_q, cnt_d;
  logic [31:0]             sig_q, sig_d, ref0_q, ref0_d, ref1_q, ref1_d;
  logic [31:0]             last_q, last_d;
  logic [FW-1:0]           frm_q, frm_d;
  logic [TW-1:0]           stall_q, stall_d;
  logic                    elen_q, elen_d, eidx_q, eidx_d;
  logic                    esig_q, esig_d, eto_q, eto_d;
  logic                    fin_q, fin_d, pass_q, pass_d;

  // Fold {im,re} into 32 bits: zero-pad to a 32-bit multiple, XOR the chunks.
  logic [SW-1:0] s_pad;
  logic [31:0]   fold;
  always_comb begin
    s_pad = '0;
    s_pad[2*OUTPUT_WIDTH-1:0] = {i_axi4s_data_tdata[DATAOUT_WIDTH +: OUTPUT_WIDTH],
                                 i_axi4s_data_tdata[0 +: OUTPUT_WIDTH]};
    fold = '0;
    for (int i = 0; i < NCH; i++) fold = fold ^ s_pad[i*32 +: 32];
  end

  logic [LOGS_FFT_LEN-1:0] exp_idx;
  always_comb begin
    for (int i = 0; i < LOGS_FFT_LEN; i++)
      exp_idx[i] = (OUT_ORDER != 0) ? cnt_q[LOGS_FFT_LEN-1-i] : cnt_q[i];
  end

  logic [31:0] sig_new;
  logic        cnt_end;
  assign sig_new = {sig_q[30:0], sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0]} ^ fold;
  assign cnt_end = &cnt_q;

  always_comb begin
    state_d = state_q; cnt_d  = cnt_q;  sig_d  = sig_q;
    ref0_d  = ref0_q;  ref1_d = ref1_q; last_d = last_q;
    frm_d   = frm_q;   stall_d = stall_q;
    elen_d  = elen_q;  eidx_d = eidx_q; esig_d = esig_q; eto_d = eto_q;
    if (i_aclken) begin
      if (i_start_test) begin
        state_d = S_RUN; cnt_d = '0; sig_d = '0; ref0_d = '0; ref1_d = '0;
        last_d = '0; frm_d = '0; stall_d = '0;
        elen_d = 1'b0; eidx_d = 1'b0; esig_d = 1'b0; eto_d = 1'b0;
      end else if (state_q == S_RUN) begin
        if (i_axi4s_data_tvalid) begin
          stall_d = '0;
          if (i_axi4s_data_tuser != exp_idx) eidx_d = 1'b1;
          if (i_axi4s_data_tlast || cnt_end) begin
            // Frame end: tlast and the N-th sample must coincide.
            if (i_axi4s_data_tlast != cnt_end) elen_d = 1'b1;
            last_d = sig_new;
            frm_d  = frm_q + 1'b1;
            cnt_d  = '0;
            sig_d  = '0;
            if (frm_q == '0)              ref0_d = sig_new;
            else if (frm_q == FW'(1))     ref1_d = sig_new;
            else if (sig_new != (frm_q[0] ? ref1_q : ref0_q)) esig_d = 1'b1;
            if (frm_q == FW'(TEST_FRAME_NUM - 1)) state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
            sig_d = sig_new;
          end
        end else begin
          stall_d = stall_q + 1'b1;
          if (stall_q == TW'(TIMEOUT_CYCLES - 1)) begin
            eto_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
    end
    fin_d  = (state_d == S_DONE);
    pass_d = fin_d & ~(elen_d | eidx_d | esig_d | eto_d);
  end

  always_ff @(posedge i_aclk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      state_q <= S_IDLE; cnt_q <= '0; sig_q <= '0; ref0_q <= '0; ref1_q <= '0;
      last_q  <= '0; frm_q <= '0; stall_q <= '0;
      elen_q  <= 1'b0; eidx_q <= 1'b0; esig_q <= 1'b0; eto_q <= 1'b0;
      fin_q   <= 1'b0; pass_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; sig_q <= sig_d; ref0_q <= ref0_d;
      ref1_q  <= ref1_d; last_q <= last_d; frm_q <= frm_d; stall_q <= stall_d;
      elen_q  <= elen_d; eidx_q <= eidx_d; esig_q <= esig_d; eto_q <= eto_d;
      fin_q   <= fin_d;  pass_q <= pass_d;
    end
  end

  assign o_chk_finished = fin_q;
  assign o_chk_pass     = pass_q;
  assign o_err_len      = elen_q;
  assign o_err_idx      = eidx_q;
  assign o_err_sig      = esig_q;
  assign o_err_timeout  = eto_q;
  assign o_frm_cnt      = frm_q;
  assign o_last_sig     = last_q;
endmodule

// File: tb/tb_ipsxb_fft_frame_chk.sv
// Bench for ipsxb_fft_frame_chk: two instances (natural and bit-reversed
// order) share one stimulus stream; a frame-level model over the list of
// accepted samples predicts every output.
module tb_ipsxb_fft_frame_chk;
  localparam int TFN = 10;
  localparam int N   = 16;
  localparam int TO  = 100;

  logic        clk = 1'b0, rstn = 1'b0, en = 1'b0, start = 1'b0;
  logic        tv = 1'b0, tl = 1'b0;
  logic [31:0] td = '0;
  logic [3:0]  tu = '0;

  logic fin, pass, el, ei, es, et;        logic [3:0] frm;   logic [31:0] last;
  logic b_fin, b_pass, b_el, b_ei, b_es, b_et; logic [3:0] b_frm; logic [31:0] b_last;

  ipsxb_fft_frame_chk #(.TEST_FRAME_NUM(TFN), .LOGS_FFT_LEN(4), .OUTPUT_WIDTH(16),
    .OUT_ORDER(0), .TIMEOUT_CYCLES(TO)) dut (
    .i_aclk(clk), .i_aresetn(rstn), .i_aclken(en), .i_start_test(start),
    .i_axi4s_data_tvalid(tv), .i_axi4s_data_tdata(td), .i_axi4s_data_tlast(tl),
    .i_axi4s_data_tuser(tu), .o_chk_finished(fin), .o_chk_pass(pass),
    .o_err_len(el), .o_err_idx(ei), .o_err_sig(es), .o_err_timeout(et),
    .o_frm_cnt(frm), .o_last_sig(last));

  ipsxb_fft_frame_chk #(.TEST_FRAME_NUM(TFN), .LOGS_FFT_LEN(4), .OUTPUT_WIDTH(16),
    .OUT_ORDER(1), .TIMEOUT_CYCLES(TO)) dut_br (
    .i_aclk(clk), .i_aresetn(rstn), .i_aclken(en), .i_start_test(start),
    .i_axi4s_data_tvalid(tv), .i_axi4s_data_tdata(td), .i_axi4s_data_tlast(tl),
    .i_axi4s_data_tuser(tu), .o_chk_finished(b_fin), .o_chk_pass(b_pass),
    .o_err_len(b_el), .o_err_idx(b_ei), .o_err_sig(b_es), .o_err_timeout(b_et),
    .o_frm_cnt(b_frm), .o_last_sig(b_last));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] d; logic [3:0] u; logic l; } smp_t;
  smp_t        acc_q[$];
  logic [31:0] pat[2][N];
  int          checks = 0, errors = 0;
  bit          toggle_en = 1'b0;
  logic [41:0] o, e;

  function automatic logic [3:0] rev4(input logic [3:0] x);
    return {x[0], x[1], x[2], x[3]};
  endfunction

  function automatic logic [41:0] obs_n();
    return {fin, pass, el, ei, es, et, frm, last};
  endfunction
  function automatic logic [41:0] obs_b();
    return {b_fin, b_pass, b_el, b_ei, b_es, b_et, b_frm, b_last};
  endfunction

  // Frame-level model: slice the accepted samples into frames (tlast or N-th
  // sample), sign each frame, compare frame k>=2 with frame k%2; anything after
  // TFN frames is ignored.
  function automatic logic [41:0] model(input int order, input bit to);
    logic [31:0] refs[2];
    logic [31:0] s, lst;
    int  nf, k;
    bit  len, idx, sg, done;
    s = '0; lst = '0; nf = 0; k = 0; len = 0; idx = 0; sg = 0;
    refs[0] = '0; refs[1] = '0;
    for (int p = 0; p < acc_q.size() && nf < TFN; p++) begin
      if (acc_q[p].u !== ((order != 0) ? rev4(4'(k)) : 4'(k))) idx = 1;
      s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ acc_q[p].d;
      if (acc_q[p].l || k == N - 1) begin
        if (acc_q[p].l != (k == N - 1)) len = 1;
        if (nf < 2) refs[nf] = s;
        else if (s != refs[nf % 2]) sg = 1;
        lst = s; nf++; k = 0; s = '0;
      end else k++;
    end
    done = (nf == TFN) || to;
    return {done, done & !(len | idx | sg | to), len, idx, sg, to, 4'(nf), lst};
  endfunction

  // All stimulus tasks start and end on a negedge; outputs read on return
  // reflect every edge that has passed.
  task automatic send(input logic [31:0] d, input logic [3:0] u, input logic l);
    if (toggle_en) begin
      en = 1'b0; tv = 1'b1; td = $urandom; tu = 4'($urandom); tl = 1'($urandom);
      @(negedge clk);
    end
    en = 1'b1; tv = 1'b1; td = d; tu = u; tl = l;
    @(negedge clk);
    tv = 1'b0; tl = 1'b0;
    acc_q.push_back('{d, u, l});
  endtask

  task automatic idle(input int n);
    repeat (n) begin en = 1'b1; tv = 1'b0; @(negedge clk); end
  endtask

  task automatic do_start();
    en = 1'b1; start = 1'b1; tv = 1'b1; td = $urandom; tu = '0; tl = 1'b1;
    @(negedge clk);
    start = 1'b0; tv = 1'b0; tl = 1'b0;
    acc_q.delete();
  endtask

  task automatic send_frame(input int f, input int order);
    for (int i = 0; i < N; i++)
      send(pat[f % 2][i], (order != 0) ? rev4(4'(i)) : 4'(i), i == N - 1);
  endtask

  task automatic test_reset();
    checks++; o = obs_n();
    if (o !== 42'd0) begin errors++; $display("FAIL reset_n got %h want 0", o); end
    checks++; o = obs_b();
    if (o !== 42'd0) begin errors++; $display("FAIL reset_b got %h want 0", o); end
    rstn = 1'b1; @(negedge clk);
    for (int i = 0; i < 4; i++) send($urandom, 4'(i), i == 3);
    acc_q.delete();
    checks++; o = obs_n();
    if (o !== 42'd0) begin errors++; $display("FAIL idle_ignore got %h want 0", o); end
  endtask

  task automatic test_nominal();
    do_start();
    checks++; o = obs_n(); e = model(0, 0);
    if (o !== e) begin errors++; $display("FAIL nom_start got %h want %h", o, e); end
    for (int f = 0; f < TFN; f++) begin
      for (int i = 0; i < N; i++) begin
        send(pat[f % 2][i], 4'(i), i == N - 1);
        if (f == TFN - 1 && i == N - 2) begin
          checks++;
          if (fin !== 1'b0) begin errors++; $display("FAIL nom_early_fin got %b want 0", fin); end
        end
      end
      checks++; o = obs_n(); e = model(0, 0);
      if (o !== e) begin errors++; $display("FAIL nom_frame%0d got %h want %h", f, o, e); end
    end
    checks++;
    if ({fin, pass, el, ei, es, et, frm} !== {6'b110000, 4'd10}) begin
      errors++; $display("FAIL nom_done got %b want 1100001010", {fin, pass, el, ei, es, et, frm});
    end
    for (int i = 0; i < 5; i++) send($urandom, 4'(i + 3), 1'b1);
    checks++; o = obs_n(); e = model(0, 0);
    if (o !== e) begin errors++; $display("FAIL nom_after_done got %h want %h", o, e); end
  endtask

  task automatic test_sig_mismatch();
    do_start();
    for (int f = 0; f < TFN; f++) begin
      for (int i = 0; i < N; i++)
        send(pat[f % 2][i] ^ ((f == 4 && i == 7) ? 32'd1 : 32'd0), 4'(i), i == N - 1);
      if (f == 3 || f == 4) begin
        checks++;
        if (es !== (f == 4)) begin errors++; $display("FAIL sig_frame%0d got %b want %b", f, es, f == 4); end
      end
    end
    checks++; o = obs_n(); e = model(0, 0);
    if (o !== e || fin !== 1'b1 || pass !== 1'b0) begin
      errors++; $display("FAIL sig_end got %h want %h", o, e);
    end
  endtask

  task automatic test_early_tlast();
    do_start();
    send_frame(0, 0); send_frame(1, 0);
    for (int i = 0; i < 10; i++) send(pat[0][i], 4'(i), i == 9);
    checks++;
    if ({el, frm} !== {1'b1, 4'd3}) begin
      errors++; $display("FAIL early_tlast got %b want 10011", {el, frm});
    end
    for (int f = 3; f < TFN; f++) send_frame(f, 0);
    checks++; o = obs_n(); e = model(0, 0);
    if (o !== e) begin errors++; $display("FAIL early_end got %h want %h", o, e); end
  endtask

  task automatic test_bitrev();
    do_start();
    send_frame(0, 1); send_frame(1, 1);
    checks++; o = obs_b(); e = model(1, 0);
    if (o !== e || b_ei !== 1'b0) begin errors++; $display("FAIL br_ok got %h want %h", o, e); end
    checks++; o = obs_n(); e = model(0, 0);
    if (o !== e) begin errors++; $display("FAIL br_nat got %h want %h", o, e); end
    do_start();
    send(pat[0][0], 4'd0, 1'b0);
    checks++;
    if (b_ei !== 1'b0) begin errors++; $display("FAIL br_cnt0 got %b want 0", b_ei); end
    send(pat[0][1], 4'd1, 1'b0);
    checks++; o = obs_b(); e = model(1, 0);
    if (o !== e || b_ei !== 1'b1) begin errors++; $display("FAIL br_cnt1 got %h want %h", o, e); end
  endtask

  task automatic test_stall();
    do_start();
    for (int f = 0; f < 3; f++) send_frame(f, 0);
    idle(TO - 1);
    checks++;
    if ({fin, et, frm} !== {2'b00, 4'd3}) begin
      errors++; $display("FAIL stall_pre got %b want 000011", {fin, et, frm});
    end
    idle(1);
    checks++; o = obs_n(); e = model(0, 1);
    if (o !== e || pass !== 1'b0) begin errors++; $display("FAIL stall_to got %h want %h", o, e); end
  endtask

  task automatic test_restart();
    do_start();
    for (int f = 0; f < 5; f++) send_frame(f, 0);
    for (int i = 0; i < 8; i++) send(pat[1][i], 4'(i), 1'b0);
    checks++;
    if (frm !== 4'd5) begin errors++; $display("FAIL rst_mid got %0d want 5", frm); end
    do_start();
    checks++; o = obs_n();
    if (o !== 42'd0) begin errors++; $display("FAIL restart_clr got %h want 0", o); end
    toggle_en = 1'b1;
    for (int f = 0; f < TFN; f++) begin
      send_frame(f, 0);
      if (f == 4) begin
        checks++; o = obs_n(); e = model(0, 0);
        if (o !== e) begin errors++; $display("FAIL toggle_mid got %h want %h", o, e); end
      end
    end
    toggle_en = 1'b0;
    checks++; o = obs_n(); e = model(0, 0);
    if (o !== e || pass !== 1'b1) begin errors++; $display("FAIL toggle_end got %h want %h", o, e); end
  endtask

  task automatic test_reset_mid();
    do_start();
    send_frame(0, 0); send_frame(1, 0);
    for (int i = 0; i < 5; i++) send(pat[0][i], 4'(i), 1'b0);
    #2 rstn = 1'b0;
    #1;
    checks++; o = obs_n();
    if (o !== 42'd0) begin errors++; $display("FAIL areset got %h want 0", o); end
    @(negedge clk); rstn = 1'b1;
    send(pat[0][0], 4'd0, 1'b1);
    acc_q.delete();
    checks++; o = obs_n();
    if (o !== 42'd0) begin errors++; $display("FAIL post_reset_idle got %h want 0", o); end
  endtask

  initial begin
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) pat[p][i] = $urandom;
    repeat (3) @(negedge clk);
    test_reset();
    test_nominal();
    test_sig_mismatch();
    test_early_tlast();
    test_bitrev();
    test_stall();
    test_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
